// File: rtl/egr_wadj_csr_mc_if.sv
// egr_wadj_csr_mc AVMM slave bundle.
// Word-addressed read/write with readdata qualifier, no waitrequest.
interface egr_wadj_csr_mc_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   avmm_address;
  logic                    avmm_read;
  logic                    avmm_write;
  logic [DATA_WIDTH-1:0]   avmm_writedata;
  logic [DATA_WIDTH/8-1:0] avmm_byteenable;
  logic [DATA_WIDTH-1:0]   avmm_readdata;
  logic                    avmm_readdata_valid;

  modport master (
    output avmm_address,
    output avmm_read,
    output avmm_write,
    output avmm_writedata,
    output avmm_byteenable,
    input  avmm_readdata,
    input  avmm_readdata_valid
  );

  modport slave (
    input  avmm_address,
    input  avmm_read,
    input  avmm_write,
    input  avmm_writedata,
    input  avmm_byteenable,
    output avmm_readdata,
    output avmm_readdata_valid
  );
endinterface

// File: rtl/egr_wadj_csr_mc.sv
// egr_wadj_csr_mc: multi-channel egress width-adjuster CSR block.
// Per-channel drop config plus saturating drop counters, 2-stage AVMM.
module egr_wadj_csr_mc #(
  parameter int unsigned BASE_ADDR = 'h0,
  parameter int NUM_CH       = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int THRESH_WIDTH = 16,
  parameter int CNT_WIDTH    = 32,
  parameter logic [THRESH_WIDTH-1:0] DEFAULT_THRESH = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  egr_wadj_csr_mc_if.slave               avmm,
  input  logic [NUM_CH-1:0]              drop_pulse,
  output logic [NUM_CH-1:0]              cfg_drop_en,
  output logic [NUM_CH*THRESH_WIDTH-1:0] cfg_drop_threshold
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int unsigned HI_ADDR = BASE_ADDR + 4 * NUM_CH;

  typedef enum logic [1:0] {
    F_CTRL = 2'd0,
    F_THR  = 2'd1,
    F_CNT  = 2'd2,
    F_STAT = 2'd3
  } fld_e;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic                  hit;
    logic [CH_W-1:0]       ch;
    fld_e                  fld;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
  } s1_t;

  logic [31:0]             addr32;
  logic [31:0]             offset;
  s1_t                     s1_d;
  s1_t                     s1;

  logic [NUM_CH-1:0]       drop_en;
  logic [THRESH_WIDTH-1:0] thr [NUM_CH];
  logic [CNT_WIDTH-1:0]    cnt [NUM_CH];
  logic [NUM_CH-1:0]       sat;

  logic                    wr_hit;
  logic                    wr_ctrl;
  logic                    wr_thr;
  logic                    clr_cnt;
  logic                    clr_sat;
  logic [DATA_WIDTH-1:0]   be_mask;
  logic [DATA_WIDTH-1:0]   thr_merged;
  logic [DATA_WIDTH-1:0]   rd_mux;

  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rvalid_q;
  logic                    unused_ok;

  assign addr32 = 32'(avmm.avmm_address);
  assign offset = addr32 - BASE_ADDR;

  // Stage-1 decode: range check and channel/field split.
  always_comb begin
    s1_d       = '0;
    s1_d.rd    = avmm.avmm_read;
    s1_d.wr    = avmm.avmm_write;
    s1_d.hit   = (addr32 >= BASE_ADDR) && (addr32 < HI_ADDR);
    s1_d.ch    = offset[CH_W+1:2];
    s1_d.fld   = fld_e'(offset[1:0]);
    s1_d.wdata = avmm.avmm_writedata;
    s1_d.be    = avmm.avmm_byteenable;
  end

  // Stage-1 request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1 <= s1_d;
    end
  end

  // Stage-2 write strobes.
  always_comb begin
    wr_hit  = s1.wr && s1.hit;
    wr_ctrl = wr_hit && (s1.fld == F_CTRL) && s1.be[0];
    wr_thr  = wr_hit && (s1.fld == F_THR);
    clr_cnt = wr_hit && (s1.fld == F_CNT) && (|s1.be);
    clr_sat = wr_hit && (s1.fld == F_STAT) && s1.be[0]
              && s1.wdata[0];
  end

  // Byte-lane merge for the threshold register.
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BE_W; b++) begin
      be_mask[b*8 +: 8] = {8{s1.be[b]}};
    end
    thr_merged = (DATA_WIDTH'(thr[s1.ch]) & ~be_mask)
               | (s1.wdata & be_mask);
  end

  // Config registers: drop enables and thresholds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_en <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        thr[c] <= DEFAULT_THRESH;
      end
    end else begin
      if (wr_ctrl) begin
        drop_en[s1.ch] <= s1.wdata[0];
      end
      if (wr_thr) begin
        thr[s1.ch] <= thr_merged[THRESH_WIDTH-1:0];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                 sel;
    logic                 clr_c;
    logic                 full;
    logic                 inc_c;
    logic                 sat_set;
    logic                 sat_clr;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 sat_q;

    assign sel     = (s1.ch == CH_W'(c));
    assign clr_c   = clr_cnt && sel;
    assign full    = &cnt_q;
    assign inc_c   = drop_pulse[c] && !clr_c && !full;
    assign sat_set = drop_pulse[c] && !clr_c && full;
    assign sat_clr = clr_sat && sel && !sat_set;

    // Drop counter: clear beats increment, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        unique case (1'b1)
          clr_c:   cnt_q <= drop_pulse[c] ? CNT_WIDTH'(1) : '0;
          inc_c:   cnt_q <= cnt_q + CNT_WIDTH'(1);
          default: ;
        endcase
      end
    end

    // Sticky saturation flag; a new event wins over W1C.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sat_q <= 1'b0;
      end else begin
        unique case (1'b1)
          sat_set: sat_q <= 1'b1;
          sat_clr: sat_q <= 1'b0;
          default: ;
        endcase
      end
    end

    assign cnt[c] = cnt_q;
    assign sat[c] = sat_q;
    assign cfg_drop_threshold[c*THRESH_WIDTH +: THRESH_WIDTH] = thr[c];
  end

  // Read mux over pre-write register state.
  always_comb begin
    rd_mux = '0;
    if (s1.hit) begin
      unique case (s1.fld)
        F_CTRL: rd_mux = DATA_WIDTH'(drop_en[s1.ch]);
        F_THR:  rd_mux = DATA_WIDTH'(thr[s1.ch]);
        F_CNT:  rd_mux = DATA_WIDTH'(cnt[s1.ch]);
        F_STAT: rd_mux = DATA_WIDTH'(sat[s1.ch]);
        default: rd_mux = '0;
      endcase
    end
  end

  // Stage-2 readdata capture; data holds while valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= s1.rd;
      if (s1.rd) begin
        rdata_q <= rd_mux;
      end
    end
  end

  assign avmm.avmm_readdata       = rdata_q;
  assign avmm.avmm_readdata_valid = rvalid_q;
  assign cfg_drop_en              = drop_en;

  assign unused_ok = ^{offset, thr_merged, s1.wdata, s1.be};

endmodule
